// File: rtl/tia_fb_writer.sv
// TIA pixel stream -> 16-bit framebuffer writer.
// Pairs even/odd pixels into words, buffers them, drains via stb/ack.
// Params: DEPTH (FIFO words, pow2 >= 4), FLUSH_TIMEOUT (0 = off).
// Ports: clk_i, rst_ni, vid_dat_i/adr_i/wr_i, flush_i, clr_ovf_i,
//   mem_stb_o/adr_o/dat_o/sel_o, mem_ack_i, busy_o, ovf_o, drop_cnt_o.
// Optional: define TIA_FB_DROP_CNT_EN to build the drop counter.
module tia_fb_writer #(
  parameter int DEPTH         = 16,
  parameter int FLUSH_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [6:0]  vid_dat_i,
  input  logic [15:0] vid_adr_i,
  input  logic        vid_wr_i,
  input  logic        flush_i,
  input  logic        clr_ovf_i,
  output logic        mem_stb_o,
  output logic [14:0] mem_adr_o,
  output logic [15:0] mem_dat_o,
  output logic [1:0]  mem_sel_o,
  input  logic        mem_ack_i,
  output logic        busy_o,
  output logic        ovf_o,
  output logic [15:0] drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW =
    (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] TO = IW'(FLUSH_TIMEOUT);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT = (AW+1)'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  // Incoming pixel, placed in its lane
  logic [14:0] px_w;
  logic [7:0]  px_b;
  logic [15:0] px_dat;
  logic [1:0]  px_sel;

  assign px_w   = vid_adr_i[15:1];
  assign px_b   = {vid_dat_i, 1'b0};
  assign px_dat = vid_adr_i[0] ? {px_b, 8'h00} : {8'h00, px_b};
  assign px_sel = vid_adr_i[0] ? 2'b10 : 2'b01;

  // Pending (partial) word
  logic        pend_v_q, pend_v_d;
  logic [14:0] pend_w_q, pend_w_d;
  logic [15:0] pend_dat_q, pend_dat_d;
  logic [1:0]  pend_sel_q, pend_sel_d;
  logic        flush_q, flush_d;
  logic [IW-1:0] idle_q, idle_d;

  logic        push;
  logic [32:0] push_word;
  logic        timeout;
  logic        can_merge;
  logic [1:0]  merged_sel;

  assign merged_sel = pend_sel_q | px_sel;
  assign can_merge  = (px_w == pend_w_q) && ((pend_sel_q & px_sel) == 2'b00);
  assign timeout    = (FLUSH_TIMEOUT != 0) && (idle_q == TO);

  always_comb begin
    idle_d = idle_q;
    if (vid_wr_i) begin
      idle_d = '0;
    end else if (idle_q != TO) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_comb begin
    pend_v_d   = pend_v_q;
    pend_w_d   = pend_w_q;
    pend_dat_d = pend_dat_q;
    pend_sel_d = pend_sel_q;
    flush_d    = flush_q;
    push       = 1'b0;
    push_word  = {pend_w_q, pend_dat_q, pend_sel_q};
    if (vid_wr_i) begin
      // A flush seen under a pixel is deferred to the next free cycle
      flush_d = flush_q | flush_i;
      if (!pend_v_q) begin
        pend_v_d   = 1'b1;
        pend_w_d   = px_w;
        pend_dat_d = px_dat;
        pend_sel_d = px_sel;
      end else if (can_merge) begin
        if (merged_sel == 2'b11) begin
          push      = 1'b1;
          push_word = {pend_w_q, pend_dat_q | px_dat, 2'b11};
          pend_v_d  = 1'b0;
        end else begin
          pend_dat_d = pend_dat_q | px_dat;
          pend_sel_d = merged_sel;
        end
      end else begin
        push       = 1'b1;
        pend_v_d   = 1'b1;
        pend_w_d   = px_w;
        pend_dat_d = px_dat;
        pend_sel_d = px_sel;
      end
    end else if (flush_i || flush_q) begin
      flush_d = 1'b0;
      if (pend_v_q) begin
        push     = 1'b1;
        pend_v_d = 1'b0;
      end
    end else if (timeout && pend_v_q) begin
      push     = 1'b1;
      pend_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_v_q   <= 1'b0;
      pend_w_q   <= '0;
      pend_dat_q <= '0;
      pend_sel_q <= '0;
      flush_q    <= 1'b0;
      idle_q     <= '0;
    end else begin
      pend_v_q   <= pend_v_d;
      pend_w_q   <= pend_w_d;
      pend_dat_q <= pend_dat_d;
      pend_sel_q <= pend_sel_d;
      flush_q    <= flush_d;
      idle_q     <= idle_d;
    end
  end

  // Word FIFO: entry = {word addr, data, sel}
  logic [32:0] fifo_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count;
  logic        empty, full;
  logic        pop, push_ok, drop;
  logic [32:0] head;
  logic [0:0]  state_q, state_d;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = (state_q == S_REQ) && mem_ack_i;
  // A pop in the same cycle frees the slot before the push lands
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign head    = fifo_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q[AW-1:0]] <= push_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Master: bus fields come straight from the FIFO head while in REQ
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_ack_i && !(count > ONE_CNT) && !push_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign mem_stb_o = (state_q == S_REQ);
  assign mem_adr_o = mem_stb_o ? head[32:18] : '0;
  assign mem_dat_o = mem_stb_o ? head[17:2]  : '0;
  assign mem_sel_o = mem_stb_o ? head[1:0]   : '0;
  assign busy_o    = pend_v_q | !empty | mem_stb_o;

  // Overflow flag: a drop beats a simultaneous clear
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf_i) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;

`ifdef TIA_FB_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf_i) drop_cnt_d = '0;
    if (drop && (drop_cnt_d != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: doc/tia_fb_writer.md
Name: tia_fb_writer

Overview:
- Sits directly downstream of the TIA video output. Consumes the TIA pixel stream (7-bit colour, 16-bit linear framebuffer address, write strobe).
- Packs even/odd pixel pairs into 16-bit words and buffers them in a small FIFO.
- Drains the FIFO to the framebuffer memory through a stb/ack write master. This decouples TIA pixel timing from memory arbitration stalls.

Parameters:
- DEPTH, 16, FIFO depth in words; power of two, minimum 4.
- FLUSH_TIMEOUT, 255, idle clk_i cycles with no vid_wr_i before a partial word is auto-flushed; 0 disables auto-flush.

Ports:
- clk_i  in  1  system clock, same clock as the TIA
- rst_ni  in  1  asynchronous, active-low reset
- vid_dat_i  in  7  TIA colour (COLUxx[7:1])
- vid_adr_i  in  16  linear pixel address (y*160+x)
- vid_wr_i  in  1  pixel valid, single-cycle pulse per pixel
- flush_i  in  1  push any partial word (driven by TIA VSYNC rising edge)
- clr_ovf_i  in  1  clears ovf_o
- mem_stb_o  out  1  write request
- mem_adr_o  out  15  word address = pixel address >> 1
- mem_dat_o  out  16  {odd,1'b0,even,1'b0}
- mem_sel_o  out  2  byte lanes; bit0 = even pixel, bit1 = odd pixel
- mem_ack_i  in  1  write accepted
- busy_o  out  1  pending word, or FIFO non-empty, or stb high
- ovf_o  out  1  sticky: a word was dropped because the FIFO was full
- drop_cnt_o  out  16  dropped-word count (see Optional Feature)

Behaviour:
- Reset: all outputs 0. FIFO empty, pending register invalid, idle counter 0. Reset asserted mid-transaction aborts it: stb drops asynchronously and the word is lost.
- Pixel byte = {vid_dat_i,1'b0}. Word address w = vid_adr_i[15:1]. Lane l = vid_adr_i[0].
- Packing, on vid_wr_i:
  - Pending invalid: load w, set the byte in lane l, set sel bit l.
  - Pending valid, same w, and sel[l]==0: merge the byte into lane l. If sel becomes 2'b11, push the word and invalidate pending in the same cycle.
  - Pending valid, different w or lane already set: push the pending word as-is, then load the new pixel into pending.
  - At most one push per cycle.
- flush_i: if pending is valid and vid_wr_i is low, push pending and invalidate. If vid_wr_i is high in the same cycle, the flush is latched and executed the next cycle. A flush with pending invalid is a no-op.
- Auto-flush: idle counter resets on every vid_wr_i. When it reaches FLUSH_TIMEOUT with pending valid, pending is pushed as a flush. The counter saturates.
- Push into a full FIFO: the word is dropped, ovf_o is set, and drop_cnt increments. clr_ovf_i clears ovf_o next cycle. If a drop and a clear happen in the same cycle, set wins.
- FIFO: ptr width log2(DEPTH)+1. full = DEPTH entries. Push and pop in the same cycle when full are allowed: the pop frees space first, so no drop.
- Master FSM:
  - IDLE: when FIFO non-empty, drive the head onto adr/dat/sel, assert mem_stb_o, go to REQ.
  - REQ: hold stb/adr/dat/sel stable until mem_ack_i. On ack, pop. If more entries remain, present the next head the following cycle and stay in REQ; else drop stb and return to IDLE.
  - ack is ignored in IDLE. The head entry stays in the FIFO until acked.
- Latency: the vid_wr_i that completes a word at edge N produces mem_stb_o high after edge N+1.
- Word ordering on the memory bus equals push order.

Optional Feature:
- Macro TIA_FB_DROP_CNT_EN.
- Defined: 16-bit drop_cnt_o counts every dropped word, saturates at 0xFFFF, and is cleared by clr_ovf_i.
- Undefined: no counter logic is built and drop_cnt_o is tied to 0. ovf_o behaviour is unchanged.

Test Plan:
- Pixel pair: vid_wr at adr 0 dat 0x1A, then adr 1 dat 0x2B, ack immediate -> one write adr 0x0000, dat 0x5634, sel 2'b11. stb high 2 cycles after the second pixel.
- Odd-only plus flush: adr 5 dat 0x7F, then flush_i -> write adr 0x0002, dat 0xFE00, sel 2'b10.
- Address break: adr 10 dat 0x01, then adr 20 dat 0x02, then flush -> write adr 5 sel 01 dat 0x0002, followed by adr 10 sel 01 dat 0x0004.
- Overflow: DEPTH=16, hold ack low, send 17 complete pairs -> 16 words buffered, ovf_o=1, drop_cnt_o=1 (macro on) or 0 (macro off). Release ack -> exactly 16 writes in order.
- Auto-flush: FLUSH_TIMEOUT=8, single pixel at adr 3, no further input -> write adr 1 sel 10 issued after the 8th idle cycle. flush_i coincident with vid_wr_i -> flush deferred one cycle, no word lost.
- Reset mid-REQ: rst_ni low while stb high with ack withheld -> stb immediately 0. After release: busy_o=0, ovf_o=0, no stale write.
